// File: rtl/psum_pkg.sv
// Shared types and helpers for the column psum accumulator.
package psum_pkg;

    localparam int PSUM_W         = 20;
    localparam int ACC_W          = 24;
    localparam int ACC_DEPTH      = 16;
    localparam int RES_FIFO_DEPTH = 4;
    localparam int IDX_W          = $clog2(ACC_DEPTH);

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [IDX_W-1:0]        idx_t;

    // One finished column result, as queued towards the output buffer.
    typedef struct packed {
        acc_t data;
        idx_t idx;
    } res_t;

    // Saturating-add result: clamped sum plus a flag telling whether it clamped.
    typedef struct packed {
        acc_t sum;
        logic sat;
    } sat_t;

    // Signed add clamped to the acc_t range; overflow shows as a mismatch between
    // the two top bits of the one-bit-wider sum.
    function automatic sat_t sat_add(input acc_t a, input acc_t b);
        logic signed [ACC_W:0] wide;
        sat_t                  r;
        wide  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        r.sat = (wide[ACC_W] != wide[ACC_W-1]);
        if (!r.sat)
            r.sum = wide[ACC_W-1:0];
        else if (wide[ACC_W])
            r.sum = {1'b1, {(ACC_W-1){1'b0}}};
        else
            r.sum = {1'b0, {(ACC_W-1){1'b1}}};
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small pointer-based synchronous FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo
    import psum_pkg::*;
#(
    parameter type T     = res_t,
    parameter int  DEPTH = RES_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset here because the head word is visible on the outputs right after reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/psum_col_accum.sv
// Column-edge psum accumulator: sums K-tile passes per output point and queues
// finished sums for the output buffer.
module psum_col_accum
    import psum_pkg::*;
#(
    parameter int P_WIDTH    = PSUM_W,
    parameter int A_WIDTH    = ACC_W,
    parameter int DEPTH      = ACC_DEPTH,
    parameter int FIFO_DEPTH = RES_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [P_WIDTH-1:0]       in_psum,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [A_WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH)-1:0] out_idx,
    output logic                     err_drop,
    output logic                     err_sat
);

    idx_t idx;
    acc_t acc [DEPTH];
    acc_t ext_psum;
    acc_t new_val;
    sat_t sum_res;
    logic beat;
    logic sat_hit;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    res_t head;

    // A beat arriving together with flush is discarded along with the rest of the tile state.
    assign beat     = in_valid && !flush;
    assign ext_psum = acc_t'($signed(in_psum));
    assign push     = beat && in_last;
    assign pop      = out_valid && out_ready;

    // Next accumulator value: first pass overwrites, later passes saturate-add.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        sum_res = sat_add(acc[idx], ext_psum);
        new_val = in_first ? ext_psum : sum_res.sum;
        sat_hit = beat && !in_first && sum_res.sat;
    end

    // Output-point index: one step per accepted beat, wrapping at the tile size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     idx <= '0;
        else if (flush) idx <= '0;
        else if (beat)  idx <= idx + 1'b1;
    end

    // Accumulator array; flush leaves the partial sums in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
        end else if (beat) begin
            acc[idx] <= new_val;
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sat  <= 1'b0;
            err_drop <= 1'b0;
        end else if (flush) begin
            err_sat  <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            err_sat  <= err_sat | sat_hit;
            err_drop <= err_drop | (push && fifo_full && !pop);
        end
    end

    sync_fifo #(
        .T     (res_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   ('{data: new_val, idx: idx}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_idx   = head.idx;

endmodule

// File: tb/tb_psum_col_accum.sv
// Self-checking bench for psum_col_accum: stimulus tasks push expected results
// into a scoreboard queue; a negedge monitor pops and compares on each handshake.
module tb_psum_col_accum;

    localparam int  PW   = 20;
    localparam int  AW   = 24;
    localparam int  D    = 16;
    localparam longint SAT_MAX = 64'sd8388607;
    localparam longint SAT_MIN = -64'sd8388608;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_psum = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_data;
    logic [3:0]    out_idx;
    logic          err_drop;
    logic          err_sat;

    typedef struct {
        longint data;
        int     idx;
    } exp_t;

    typedef struct {
        int     psum;
        logic   first;
        logic   last;
        longint exp_data;
        int     exp_idx;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[D];
    int   errors = 0;
    int   checks = 0;

    psum_col_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_psum   (in_psum),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .err_drop  (err_drop),
        .err_sat   (err_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One input beat, driven just after a clock edge and held over the next one.
    task automatic beat(input int psum, input logic first, input logic last);
        in_valid = 1'b1;
        in_psum  = PW'(psum);
        in_first = first;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input logic with_beat);
        flush    = 1'b1;
        in_valid = with_beat;
        in_psum  = PW'(999);
        in_first = 1'b1;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Let the consumer empty the FIFO; a timeout counts as a failed comparison.
    task automatic wait_drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, longint'(sb.size()), 0);
        check({name, "_out_valid_low"}, longint'(out_valid), 0);
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop_idx", longint'(out_idx), -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_data", longint'($signed(out_data)), e.data);
                check("pop_idx", longint'(out_idx), longint'(e.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < D; k++) vecs[k] = '{k, 1'b1, 1'b1, longint'(k), k};

        // Reset state
        #12;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_idx", longint'(out_idx), 0);
        check("rst_err_drop", longint'(err_drop), 0);
        check("rst_err_sat", longint'(err_sat), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single pass, table-driven
        out_ready = 1'b1;
        for (int k = 0; k < D; k++) begin
            sb.push_back('{vecs[k].exp_data, vecs[k].exp_idx});
            beat(vecs[k].psum, vecs[k].first, vecs[k].last);
            if (k == 0) check("t1_latency_out_valid", longint'(out_valid), 1);
        end
        wait_drain("t1");

        // 2: three passes of 5
        do_flush(1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < D; k++) begin
                if (p == 2) sb.push_back('{15, k});
                beat(5, p == 0, p == 2);
            end
            if (p == 1) check("t2_no_out_before_last", longint'(out_valid), 0);
        end
        wait_drain("t2");

        // 3: saturation, positive then negative
        for (int sgn = 0; sgn < 2; sgn++) begin
            int     v;
            longint lim;
            v   = (sgn == 0) ? 524287 : -524288;
            lim = (sgn == 0) ? SAT_MAX : SAT_MIN;
            do_flush(1'b0);
            check("t3_err_sat_cleared", longint'(err_sat), 0);
            for (int p = 0; p < 17; p++) begin
                for (int k = 0; k < D; k++) begin
                    if (p == 16) sb.push_back('{lim, k});
                    beat(v, p == 0, p == 16);
                end
                if (p == 15) check("t3_no_sat_at_16", longint'(err_sat), 0);
            end
            check("t3_err_sat", longint'(err_sat), 1);
            wait_drain("t3");
        end

        // 4: backpressure over a whole last pass
        do_flush(1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (k < 4) sb.push_back('{100 + k, k});
            beat(100 + k, 1'b1, 1'b1);
            if (k == 4 || k == 15) check("t4_head_stable", longint'($signed(out_data)), 100);
        end
        check("t4_out_valid_held", longint'(out_valid), 1);
        check("t4_head_idx", longint'(out_idx), 0);
        check("t4_err_drop", longint'(err_drop), 1);
        wait_drain("t4");

        // 5: push into full FIFO with simultaneous pop
        do_flush(1'b0);
        check("t5_err_drop_cleared", longint'(err_drop), 0);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{200 + k, k});
            beat(200 + k, 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        sb.push_back('{204, 4});
        beat(204, 1'b1, 1'b1);
        check("t5_no_err_drop", longint'(err_drop), 0);
        wait_drain("t5");

        // 6: async reset mid pass 2
        do_flush(1'b0);
        out_ready = 1'b0;
        beat(300, 1'b1, 1'b1);
        for (int k = 1; k < D; k++) beat(7, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) beat(7, 1'b0, 1'b0);
        check("t6_out_valid_before_rst", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_out_valid", longint'(out_valid), 0);
        check("t6_async_out_idx", longint'(out_idx), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < D; k++) begin
            sb.push_back('{3 * k - 20, k});
            beat(3 * k - 20, 1'b1, 1'b1);
        end
        wait_drain("t6");

        // 7: flush mid pass keeps acc, resets idx, drops the same-cycle beat
        do_flush(1'b0);
        for (int k = 0; k < D; k++) beat(k + 1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) beat(10, 1'b0, 1'b0);
        do_flush(1'b1);
        check("t7_flush_out_valid", longint'(out_valid), 0);
        for (int k = 0; k < D; k++) begin
            sb.push_back('{(k < 6) ? k + 12 : k + 2, k});
            beat(1, 1'b0, 1'b1);
        end
        wait_drain("t7");
        check("t7_err_sat", longint'(err_sat), 0);
        check("t7_err_drop", longint'(err_drop), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
